// File: rtl/axi4_slave_bram.sv
// AXI4 slave backed by an on-chip word array: independent write/read FSMs,
// FIXED and INCR bursts of full-width beats, SLVERR for out-of-range or malformed bursts.
module axi4_slave_bram #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 512,
    parameter int                        AXI_ID_WIDTH   = 16,
    parameter int                        MEM_DEPTH      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_areset,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic [15:0]                 s_axi_awuser,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic [15:0]                 s_axi_aruser,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int IW     = IDX_W + 1;
    localparam int WA     = AXI_ADDR_WIDTH + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // Whole-burst check: the last beat index is computed one bit wider than the
    // address so a burst running off the top of the address space still flags.
    function automatic logic f_burst_err(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                         input logic [7:0] len,
                                         input logic [2:0] size,
                                         input logic [1:0] burst);
        logic [WA-1:0] v_first;
        logic [WA-1:0] v_last;
        v_first = WA'((addr - BASE_ADDR) >> LSB);
        v_last  = (burst == 2'b00) ? v_first : v_first + WA'(len);
        return (burst == 2'b11) || (size != 3'(LSB)) || (addr < BASE_ADDR) ||
               (v_last >= WA'(MEM_DEPTH));
    endfunction

    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    w_state_t  r_w_state;
    logic [IW-1:0] r_w_idx;
    logic [7:0]    r_w_len;
    logic [8:0]    r_w_cnt;
    logic          r_w_fixed;
    logic          r_w_err;
    logic          r_w_over;

    r_state_t  r_r_state;
    logic [IW-1:0] r_r_idx;
    logic [7:0]    r_r_len;
    logic [8:0]    r_r_cnt;
    logic          r_r_fixed;
    logic          r_r_err;

    logic w_aw_err;
    logic w_ar_err;
    logic w_wr_en;
    logic w_unused;

    assign w_aw_err = f_burst_err(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
    assign w_ar_err = f_burst_err(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
    assign w_wr_en  = (r_w_state == W_DATA) && s_axi_wvalid && !r_w_err &&
                      (r_w_idx < IW'(MEM_DEPTH));
    assign w_unused = ^{s_axi_awuser, s_axi_aruser};

    // Array has no reset so its contents survive s_axi_areset.
    always_ff @(posedge s_axi_aclk) begin
        if (w_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    r_mem[r_w_idx[IDX_W-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_w_state     <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= RESP_OKAY;
            r_w_idx       <= '0;
            r_w_len       <= '0;
            r_w_cnt       <= '0;
            r_w_fixed     <= 1'b0;
            r_w_err       <= 1'b0;
            r_w_over      <= 1'b0;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        r_w_idx       <= IW'((s_axi_awaddr - BASE_ADDR) >> LSB);
                        r_w_len       <= s_axi_awlen;
                        r_w_cnt       <= '0;
                        r_w_fixed     <= (s_axi_awburst == 2'b00);
                        r_w_err       <= w_aw_err;
                        r_w_over      <= 1'b0;
                        s_axi_bid     <= s_axi_awid;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        r_w_state     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        r_w_cnt <= r_w_cnt + 9'd1;
                        // Index parks once past the array so late beats never alias low words.
                        if (!r_w_fixed && (r_w_idx < IW'(MEM_DEPTH))) begin
                            r_w_idx <= r_w_idx + IW'(1);
                        end
                        if (s_axi_wlast) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (r_w_err || r_w_over || (r_w_cnt != {1'b0, r_w_len}))
                                            ? RESP_SLVERR : RESP_OKAY;
                            r_w_state    <= W_RESP;
                        end else if (r_w_cnt >= {1'b0, r_w_len}) begin
                            r_w_over <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_bresp   <= RESP_OKAY;
                        s_axi_awready <= 1'b1;
                        r_w_state     <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    // Read data is captured in R_FETCH with non-blocking semantics, so a write to
    // the same word on the same edge is not seen (read-first).
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_r_state     <= R_IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
            s_axi_rid     <= '0;
            r_r_idx       <= '0;
            r_r_len       <= '0;
            r_r_cnt       <= '0;
            r_r_fixed     <= 1'b0;
            r_r_err       <= 1'b0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_r_idx       <= IW'((s_axi_araddr - BASE_ADDR) >> LSB);
                        r_r_len       <= s_axi_arlen;
                        r_r_cnt       <= '0;
                        r_r_fixed     <= (s_axi_arburst == 2'b00);
                        r_r_err       <= w_ar_err;
                        s_axi_rid     <= s_axi_arid;
                        s_axi_arready <= 1'b0;
                        r_r_state     <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    s_axi_rdata  <= r_r_err ? '0 : r_mem[r_r_idx[IDX_W-1:0]];
                    s_axi_rresp  <= r_r_err ? RESP_SLVERR : RESP_OKAY;
                    s_axi_rlast  <= (r_r_cnt == {1'b0, r_r_len});
                    s_axi_rvalid <= 1'b1;
                    r_r_state    <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        if (s_axi_rlast) begin
                            s_axi_arready <= 1'b1;
                            r_r_state     <= R_IDLE;
                        end else begin
                            r_r_cnt <= r_r_cnt + 9'd1;
                            if (!r_r_fixed) begin
                                r_r_idx <= r_r_idx + IW'(1);
                            end
                            r_r_state <= R_FETCH;
                        end
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_slave_bram.sv
// Bench for axi4_slave_bram: drives AXI bursts, keeps a byte-accurate array model and
// checks B and R channel traffic against expected queues.
module tb_axi4_slave_bram;
    localparam int DW    = 512;
    localparam int IDW   = 16;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int CW    = 1 + 2 + IDW + DW;
    localparam int TMO   = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   s_axi_awaddr = '0;
    logic [IDW-1:0]  s_axi_awid = '0;
    logic [7:0]      s_axi_awlen = '0;
    logic [2:0]      s_axi_awsize = '0;
    logic [1:0]      s_axi_awburst = '0;
    logic [15:0]     s_axi_awuser = '0;
    logic            s_axi_awvalid = 1'b0;
    logic            s_axi_awready;
    logic [DW-1:0]   s_axi_wdata = '0;
    logic [DW/8-1:0] s_axi_wstrb = '0;
    logic            s_axi_wlast = 1'b0;
    logic            s_axi_wvalid = 1'b0;
    logic            s_axi_wready;
    logic [IDW-1:0]  s_axi_bid;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready = 1'b0;
    logic [AW-1:0]   s_axi_araddr = '0;
    logic [IDW-1:0]  s_axi_arid = '0;
    logic [7:0]      s_axi_arlen = '0;
    logic [2:0]      s_axi_arsize = '0;
    logic [1:0]      s_axi_arburst = '0;
    logic [15:0]     s_axi_aruser = '0;
    logic            s_axi_arvalid = 1'b0;
    logic            s_axi_arready;
    logic [IDW-1:0]  s_axi_rid;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rlast;
    logic            s_axi_rvalid;
    logic            s_axi_rready = 1'b0;

    logic [DW-1:0]    model [DEPTH];
    logic [CW-1:0]    r_exp_q[$];
    logic [IDW+1:0]   b_exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi4_slave_bram dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awuser(s_axi_awuser),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_aruser(s_axi_aruser),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic [AW-1:0] addr, input logic [7:0] len,
                                     input logic [1:0] burst, input logic [2:0] size);
        longint last;
        last = longint'(addr / 64) + ((burst == 2'b00) ? 0 : longint'(len));
        return (burst == 2'b11) || (size != 3'd6) || (last >= DEPTH);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [AW-1:0] addr, input logic [IDW-1:0] id,
                           input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = len;
        s_axi_awburst = burst; s_axi_awsize = size; s_axi_awuser = 16'($urandom());
        s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("aw_tmo", s_axi_awready, 1);
        tick();
        s_axi_awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [AW-1:0] addr, input logic [IDW-1:0] id,
                           input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = len;
        s_axi_arburst = burst; s_axi_arsize = size; s_axi_aruser = 16'($urandom());
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("ar_tmo", s_axi_arready, 1);
        tick();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input logic [IDW-1:0] id,
                            input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
                            input int nbeats, input logic [63:0] strb, input logic ones,
                            input logic chk_lat);
        logic err;
        logic [DW-1:0] d;
        int idx;
        int n;
        int stall;
        err = exp_err(addr, len, burst, size);
        b_exp_q.push_back({id, (err || nbeats != int'(len) + 1) ? 2'b10 : 2'b00});
        aw_send(addr, id, len, burst, size);
        if (chk_lat) check("wready_lat", s_axi_wready, 1);
        for (int b = 0; b < nbeats; b++) begin
            d = ones ? {DW{1'b1}} : rand_word();
            s_axi_wdata = d; s_axi_wstrb = strb; s_axi_wlast = (b == nbeats - 1);
            s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < TMO) begin tick(); n++; end
            if (n >= TMO) check("w_tmo", s_axi_wready, 1);
            tick();
            idx = int'(addr / 64) + ((burst == 2'b00) ? 0 : b);
            if (!err && idx < DEPTH) begin
                for (int k = 0; k < 64; k++) if (strb[k]) model[idx][k*8 +: 8] = d[k*8 +: 8];
            end
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("b_tmo", s_axi_bvalid, 1);
        if (chk_lat) check("b_lat", n, 0);
        stall = $urandom_range(0, 2);
        for (int s = 0; s < stall; s++) begin check("b_hold", s_axi_bvalid, 1); tick(); end
        s_axi_bready = 1'b1;
        check("bresp", {s_axi_bid, s_axi_bresp}, b_exp_q.pop_front());
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input logic [IDW-1:0] id,
                            input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
                            input int stall_fixed);
        logic err;
        int idx;
        int n;
        int stall;
        err = exp_err(addr, len, burst, size);
        for (int i = 0; i <= int'(len); i++) begin
            idx = int'(addr / 64) + ((burst == 2'b00) ? 0 : i);
            r_exp_q.push_back({(i == int'(len)), err ? 2'b10 : 2'b00, id,
                               err ? {DW{1'b0}} : model[idx]});
        end
        ar_send(addr, id, len, burst, size);
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!s_axi_rvalid && n < TMO) begin tick(); n++; end
            if (n >= TMO) check("r_tmo", s_axi_rvalid, 1);
            check("r_lat", n, 1);
            stall = (stall_fixed >= 0) ? stall_fixed : $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                check("r_hold_v", s_axi_rvalid, 1);
                check("r_hold", {s_axi_rlast, s_axi_rresp, s_axi_rid, s_axi_rdata}, r_exp_q[0]);
                tick();
            end
            s_axi_rready = 1'b1;
            check("rbeat", {s_axi_rlast, s_axi_rresp, s_axi_rid, s_axi_rdata}, r_exp_q.pop_front());
            tick();
            s_axi_rready = 1'b0;
        end
    endtask

    initial begin
        int n;
        int wd;
        logic [7:0] ln;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", s_axi_awready, 1);
        check("rst_arready", s_axi_arready, 1);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        rst = 1'b0;
        tick();

        wr_burst(32'h40, 16'h1234, 8'd0, 2'b00, 3'd6, 1, {64{1'b1}}, 1'b0, 1'b1);
        rd_burst(32'h40, 16'h5678, 8'd0, 2'b00, 3'd6, 0);

        wr_burst(32'h0, 16'h0011, 8'd3, 2'b01, 3'd6, 4, {64{1'b1}}, 1'b0, 1'b0);
        rd_burst(32'h0, 16'h0022, 8'd3, 2'b01, 3'd6, -1);

        wr_burst(32'h80, 16'h0033, 8'd0, 2'b01, 3'd6, 1, {64{1'b1}}, 1'b1, 1'b0);
        wr_burst(32'h80, 16'h0034, 8'd0, 2'b01, 3'd6, 1, 64'hF, 1'b0, 1'b0);
        rd_burst(32'h80, 16'h0035, 8'd0, 2'b01, 3'd6, 0);

        rd_burst(DEPTH * 64, 16'h0044, 8'd0, 2'b01, 3'd6, 0);
        wr_burst(DEPTH * 64, 16'h0045, 8'd0, 2'b01, 3'd6, 1, {64{1'b1}}, 1'b0, 1'b0);
        wr_burst((DEPTH - 1) * 64, 16'h0046, 8'd0, 2'b01, 3'd6, 1, {64{1'b1}}, 1'b0, 1'b0);
        wr_burst((DEPTH - 1) * 64, 16'h0047, 8'd1, 2'b01, 3'd6, 2, {64{1'b1}}, 1'b0, 1'b0);
        rd_burst((DEPTH - 1) * 64, 16'h0048, 8'd0, 2'b01, 3'd6, 0);

        wr_burst(32'h2000, 16'h0055, 8'd3, 2'b01, 3'd6, 2, {64{1'b1}}, 1'b0, 1'b0);
        wr_burst(32'h3000, 16'h0056, 8'd1, 2'b01, 3'd6, 3, {64{1'b1}}, 1'b0, 1'b0);
        wr_burst(32'h4000, 16'h0057, 8'd0, 2'b01, 3'd5, 1, {64{1'b1}}, 1'b0, 1'b0);
        rd_burst(32'h40, 16'h0058, 8'd0, 2'b11, 3'd6, 0);
        rd_burst(32'h0, 16'h0059, 8'd3, 2'b01, 3'd6, 10);

        wr_burst(32'h5000, 16'h0066, 8'd3, 2'b00, 3'd6, 4, {64{1'b1}}, 1'b0, 1'b0);
        rd_burst(32'h5000, 16'h0067, 8'd2, 2'b00, 3'd6, -1);
        wr_burst(32'h5400, 16'h0068, 8'd1, 2'b10, 3'd6, 2, {64{1'b1}}, 1'b0, 1'b0);
        rd_burst(32'h5400, 16'h0069, 8'd1, 2'b10, 3'd6, -1);

        fork
            wr_burst(32'h6000, 16'h0077, 8'd1, 2'b01, 3'd6, 2, {64{1'b1}}, 1'b0, 1'b0);
            rd_burst(32'h40, 16'h0078, 8'd0, 2'b01, 3'd6, -1);
        join

        for (int it = 0; it < 16; it++) begin
            wd = $urandom_range(200, 900);
            ln = 8'($urandom_range(0, 7));
            wr_burst(32'(wd * 64), 16'($urandom()), ln, 2'b01, 3'd6, int'(ln) + 1,
                     {$urandom(), $urandom()}, 1'b0, 1'b0);
            rd_burst(32'(wd * 64), 16'($urandom()), ln, 2'b01, 3'd6, -1);
        end

        ar_send(32'h0, 16'h0099, 8'd3, 2'b01, 3'd6);
        n = 0;
        while (!s_axi_rvalid && n < TMO) begin tick(); n++; end
        check("rst_mid_rvalid_pre", s_axi_rvalid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_rvalid", s_axi_rvalid, 0);
        check("rst_mid_arready", s_axi_arready, 1);
        check("rst_mid_rdata", s_axi_rdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        rd_burst(32'h0, 16'h00AA, 8'd3, 2'b01, 3'd6, -1);
        rd_burst(32'h80, 16'h00AB, 8'd0, 2'b01, 3'd6, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
